// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus fabric: FSM states, slot map, default timeout,
// and the captured-transaction record held while a transfer is in flight.
package io_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 16;

   localparam int SLOT_LED   = 0;
   localparam int SLOT_TIMER = 1;
   localparam int SLOT_UART  = 2;

   typedef struct packed {
      logic        wr;
      logic [31:0] address;
      logic [31:0] wr_data;
   } txn_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant; priority starts after the last winner.
// Latency 0 (grant from req); pointer moves only on advance, so an unserved grant simply waits.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] next_ptr;
   logic             found;

   // Scan offsets from the pointer; the first requester found wins.
   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      for (int off = 0; off < N; off++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (((int'(ptr) + off) % N) == i)) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               next_ptr = PTR_W'((i + 1) % N);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= next_ptr;
      end
   end

endmodule

// File: rtl/io_bus_fabric.sv
// Multi-master to IO-slot bridge, one transaction in flight; strobe 1 cycle after req, ack/err 1 cycle after ready.
// Masters hold m_req until m_ack/m_err; slow slots stall via io_bus_s_ready up to TIMEOUT_CYCLES, then error.
module io_bus_fabric
   import io_bus_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLOTS      = 8,
   parameter int SLOT_LSB       = 6,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MASTERS-1:0]    m_req,
   input  logic [NUM_MASTERS-1:0]    m_wr,
   input  logic [NUM_MASTERS*32-1:0] m_address,
   input  logic [NUM_MASTERS*32-1:0] m_wr_data,
   output logic [31:0]               m_rd_data,
   output logic [NUM_MASTERS-1:0]    m_ack,
   output logic [NUM_MASTERS-1:0]    m_err,
   output logic                      io_bus_s_rd_en,
   output logic                      io_bus_s_wr_en,
   output logic [NUM_SLOTS-1:0]      io_bus_s_cs,
   output logic [31:0]               io_bus_s_address,
   output logic [31:0]               io_bus_s_wr_data,
   input  logic [NUM_SLOTS*32-1:0]   io_bus_s_rd_data,
   input  logic [NUM_SLOTS-1:0]      io_bus_s_ready
);

   localparam int         SLOT_W    = $clog2(NUM_SLOTS);
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                 state;
   txn_t                   txn;
   logic [NUM_MASTERS-1:0] gnt_q;
   logic [SLOT_W-1:0]      slot;
   logic                   err_flag;
   logic [7:0]             wait_cnt;

   logic [NUM_MASTERS-1:0] arb_grant;
   logic                   advance;
   txn_t                   req_txn;
   logic [SLOT_W-1:0]      req_slot;
   logic                   req_bad;
   logic [NUM_SLOTS-1:0]   req_cs;
   logic                   slot_ready;
   logic [31:0]            slot_rdata;

   assign advance = (state == ST_IDLE) && (|m_req);

   rr_arbiter #(.N(NUM_MASTERS)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (m_req),
      .advance (advance),
      .grant   (arb_grant)
   );

   // Decode the winner's request in IDLE so strobe and cs can be registered on the grant edge.
   always_comb begin
      req_txn = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (arb_grant[m]) begin
            req_txn.wr      = m_wr[m];
            req_txn.address = m_address[m*32 +: 32];
            req_txn.wr_data = m_wr_data[m*32 +: 32];
         end
      end
      req_slot = req_txn.address[SLOT_LSB +: SLOT_W];
      req_bad  = (int'(req_slot) >= NUM_SLOTS);
      req_cs   = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (!req_bad && (req_slot == SLOT_W'(s))) req_cs[s] = 1'b1;
      end
   end

   always_comb begin
      slot_ready = 1'b0;
      slot_rdata = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (slot == SLOT_W'(s)) begin
            slot_ready = io_bus_s_ready[s];
            slot_rdata = io_bus_s_rd_data[s*32 +: 32];
         end
      end
   end

   assign io_bus_s_address = txn.address;
   assign io_bus_s_wr_data = txn.wr_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         txn            <= '0;
         gnt_q          <= '0;
         slot           <= '0;
         err_flag       <= 1'b0;
         wait_cnt       <= '0;
         m_rd_data      <= '0;
         m_ack          <= '0;
         m_err          <= '0;
         io_bus_s_rd_en <= 1'b0;
         io_bus_s_wr_en <= 1'b0;
         io_bus_s_cs    <= '0;
      end else begin
         io_bus_s_rd_en <= 1'b0;
         io_bus_s_wr_en <= 1'b0;
         m_ack          <= '0;
         m_err          <= '0;
         case (state)
            ST_IDLE: begin
               if (|m_req) begin
                  gnt_q       <= arb_grant;
                  txn         <= req_txn;
                  slot        <= req_slot;
                  err_flag    <= req_bad;
                  wait_cnt    <= '0;
                  io_bus_s_cs <= req_cs;
                  if (!req_bad) begin
                     io_bus_s_rd_en <= !req_txn.wr;
                     io_bus_s_wr_en <= req_txn.wr;
                  end
                  state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (err_flag) begin
                  m_err     <= gnt_q;
                  m_rd_data <= '0;
                  state     <= ST_RESP;
               end else if (slot_ready) begin
                  m_ack       <= gnt_q;
                  m_rd_data   <= txn.wr ? 32'h0 : slot_rdata;
                  io_bus_s_cs <= '0;
                  state       <= ST_RESP;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (slot_ready) begin
                  m_ack       <= gnt_q;
                  m_rd_data   <= txn.wr ? 32'h0 : slot_rdata;
                  io_bus_s_cs <= '0;
                  state       <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt == WAIT_LAST) begin
                     err_flag    <= 1'b1;
                     m_err       <= gnt_q;
                     m_rd_data   <= '0;
                     io_bus_s_cs <= '0;
                     state       <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               err_flag <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed bench for io_bus_fabric with six slots so slot indices 6 and 7 decode as bad.
module tb_io_bus_fabric;
   import io_bus_pkg::*;

   localparam int NM = 2;
   localparam int NS = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [NM-1:0]   m_req;
   logic [NM-1:0]   m_wr;
   logic [NM*32-1:0] m_address;
   logic [NM*32-1:0] m_wr_data;
   logic [31:0]     m_rd_data;
   logic [NM-1:0]   m_ack;
   logic [NM-1:0]   m_err;
   logic            s_rd_en;
   logic            s_wr_en;
   logic [NS-1:0]   s_cs;
   logic [31:0]     s_address;
   logic [31:0]     s_wr_data;
   logic [NS*32-1:0] s_rd_data;
   logic [NS-1:0]   s_ready;

   int total = 0;
   int bad   = 0;
   int wr_pulses = 0;

   always #5 clk = ~clk;

   io_bus_fabric #(
      .NUM_MASTERS    (NM),
      .NUM_SLOTS      (NS),
      .SLOT_LSB       (6),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .m_req            (m_req),
      .m_wr             (m_wr),
      .m_address        (m_address),
      .m_wr_data        (m_wr_data),
      .m_rd_data        (m_rd_data),
      .m_ack            (m_ack),
      .m_err            (m_err),
      .io_bus_s_rd_en   (s_rd_en),
      .io_bus_s_wr_en   (s_wr_en),
      .io_bus_s_cs      (s_cs),
      .io_bus_s_address (s_address),
      .io_bus_s_wr_data (s_wr_data),
      .io_bus_s_rd_data (s_rd_data),
      .io_bus_s_ready   (s_ready)
   );

   always @(negedge clk) if (s_wr_en) wr_pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_ack;
      int wr_base;
      logic [NM-1:0] exp_ack [4];
      logic [31:0]   exp_dat [4];

      rst       = 1'b1;
      m_req     = '0;
      m_wr      = '0;
      m_address = '0;
      m_wr_data = '0;
      s_ready   = 6'b000011;
      s_rd_data = '0;
      s_rd_data[0*32 +: 32] = 32'h0000_0A0A;
      s_rd_data[1*32 +: 32] = 32'hDEAD_BEEF;
      s_rd_data[2*32 +: 32] = 32'h5555_AAAA;
      s_rd_data[3*32 +: 32] = 32'h3333_3333;

      repeat (3) tick();
      chk("rst_ack",   32'(m_ack), 32'h0);
      chk("rst_err",   32'(m_err), 32'h0);
      chk("rst_cs",    32'(s_cs), 32'h0);
      chk("rst_rden",  32'(s_rd_en), 32'h0);
      chk("rst_rdata", m_rd_data, 32'h0);
      rst = 1'b0;
      tick();

      // Zero-wait read, master 0, slot 1
      m_req = 2'b01; m_wr = 2'b00; m_address[31:0] = 32'h40;
      tick();
      chk("zw_rden",  32'(s_rd_en), 32'h1);
      chk("zw_wren",  32'(s_wr_en), 32'h0);
      chk("zw_cs",    32'(s_cs), 32'h02);
      chk("zw_addr",  s_address, 32'h40);
      chk("zw_ack1",  32'(m_ack), 32'h0);
      tick();
      chk("zw_ack",   32'(m_ack), 32'h1);
      chk("zw_err",   32'(m_err), 32'h0);
      chk("zw_rdata", m_rd_data, 32'hDEAD_BEEF);
      chk("zw_csoff", 32'(s_cs), 32'h0);
      m_req = 2'b00;
      tick();
      chk("zw_ackend", 32'(m_ack), 32'h0);

      // Write with three wait states, master 1, slot 2
      wr_base = wr_pulses;
      m_req = 2'b10; m_wr = 2'b10;
      m_address[63:32] = 32'(SLOT_UART << 6);
      m_wr_data[63:32] = 32'h1234;
      tick();
      chk("ws_wren", 32'(s_wr_en), 32'h1);
      chk("ws_cs",   32'(s_cs), 32'h04);
      chk("ws_wd1",  s_wr_data, 32'h1234);
      m_address[63:32] = 32'h0000_0040;
      m_wr_data[63:32] = 32'hFFFF_FFFF;
      tick();
      chk("ws_wren2", 32'(s_wr_en), 32'h0);
      chk("ws_cs2",   32'(s_cs), 32'h04);
      chk("ws_wd2",   s_wr_data, 32'h1234);
      chk("ws_addr2", s_address, 32'h80);
      tick();
      chk("ws_ack3",  32'(m_ack), 32'h0);
      tick();
      s_ready[2] = 1'b1;
      chk("ws_ack4",  32'(m_ack), 32'h0);
      chk("ws_wd4",   s_wr_data, 32'h1234);
      tick();
      chk("ws_ack",    32'(m_ack), 32'h2);
      chk("ws_err",    32'(m_err), 32'h0);
      chk("ws_rdzero", m_rd_data, 32'h0);
      chk("ws_pulses", 32'(wr_pulses - wr_base), 32'h1);
      s_ready[2] = 1'b0;
      m_req = 2'b00; m_wr = 2'b00;
      tick();

      // Timeout, master 0, slot 3 never ready
      m_req = 2'b01; m_address[31:0] = 32'hC0;
      tick();
      chk("to_rden", 32'(s_rd_en), 32'h1);
      chk("to_cs",   32'(s_cs), 32'h08);
      repeat (16) tick();
      chk("to_err17", 32'(m_err), 32'h0);
      chk("to_cs17",  32'(s_cs), 32'h08);
      tick();
      chk("to_err",   32'(m_err), 32'h1);
      chk("to_noack", 32'(m_ack), 32'h0);
      chk("to_csoff", 32'(s_cs), 32'h0);
      m_req = 2'b00;
      tick();
      chk("to_errend", 32'(m_err), 32'h0);

      // Bad slot 7, master 0
      m_req = 2'b01; m_address[31:0] = 32'h1C0;
      tick();
      chk("b7_rden", 32'(s_rd_en), 32'h0);
      chk("b7_cs",   32'(s_cs), 32'h0);
      tick();
      chk("b7_err",  32'(m_err), 32'h1);
      chk("b7_ack",  32'(m_ack), 32'h0);
      m_req = 2'b00;
      tick();

      // First out-of-range slot (6), master 1 write
      m_req = 2'b10; m_wr = 2'b10; m_address[63:32] = 32'h180;
      tick();
      chk("b6_wren", 32'(s_wr_en), 32'h0);
      chk("b6_cs",   32'(s_cs), 32'h0);
      tick();
      chk("b6_err",  32'(m_err), 32'h2);
      m_req = 2'b00; m_wr = 2'b00;
      tick();

      // Contention: both request continuously
      m_address[31:0]  = 32'h40;
      m_address[63:32] = 32'h00;
      exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_dat = '{32'hDEAD_BEEF, 32'h0000_0A0A, 32'hDEAD_BEEF, 32'h0000_0A0A};
      m_req = 2'b11;
      n_ack = 0;
      for (int c = 0; c < 40 && n_ack < 4; c++) begin
         tick();
         if (m_ack != '0) begin
            chk($sformatf("rr_ack%0d", n_ack), 32'(m_ack), 32'(exp_ack[n_ack]));
            chk($sformatf("rr_dat%0d", n_ack), m_rd_data, exp_dat[n_ack]);
            n_ack++;
         end
      end
      m_req = 2'b00;
      chk("rr_count", 32'(n_ack), 32'd4);
      tick();

      // Reset during a stalled access by master 0
      m_req = 2'b01; m_address[31:0] = 32'hC0;
      repeat (3) tick();
      chk("rw_cs_wait", 32'(s_cs), 32'h08);
      rst = 1'b1;
      tick();
      chk("rw_ack",   32'(m_ack), 32'h0);
      chk("rw_err",   32'(m_err), 32'h0);
      chk("rw_cs",    32'(s_cs), 32'h0);
      chk("rw_addr",  s_address, 32'h0);
      chk("rw_rdata", m_rd_data, 32'h0);
      rst = 1'b0;
      m_req = 2'b11;
      m_address[31:0]  = 32'h40;
      m_address[63:32] = 32'h00;
      tick();
      chk("rw_gcs",  32'(s_cs), 32'h02);
      chk("rw_gerr", 32'(m_err), 32'h0);
      tick();
      chk("rw_gack", 32'(m_ack), 32'h1);
      m_req = 2'b00;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
